// File: rtl/vec_mem_responder.sv
// Memory-side responder: one request per cycle into a small register file, with
// a one-entry response slot per requestor so back-pressure stays per requestor.
module vec_mem_responder #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_mem_req_valid,
  output logic              io_mem_req_ready,
  input  logic [ID_W-1:0]   io_mem_req_bits_id,
  input  logic              io_mem_req_bits_rw,
  input  logic [ADDR_W-1:0] io_mem_req_bits_addr,
  input  logic [DATA_W-1:0] io_mem_req_bits_data,
  output logic              io_requestor_0_resp_valid,
  input  logic              io_requestor_0_resp_ready,
  output logic [DATA_W-1:0] io_requestor_0_resp_bits_data,
  output logic              io_requestor_0_resp_bits_rw,
  output logic              io_requestor_1_resp_valid,
  input  logic              io_requestor_1_resp_ready,
  output logic [DATA_W-1:0] io_requestor_1_resp_bits_data,
  output logic              io_requestor_1_resp_bits_rw,
  output logic              io_requestor_2_resp_valid,
  input  logic              io_requestor_2_resp_ready,
  output logic [DATA_W-1:0] io_requestor_2_resp_bits_data,
  output logic              io_requestor_2_resp_bits_rw,
  output logic              io_requestor_3_resp_valid,
  input  logic              io_requestor_3_resp_ready,
  output logic [DATA_W-1:0] io_requestor_3_resp_bits_data,
  output logic              io_requestor_3_resp_bits_rw,
  output logic              io_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NCH   = 4;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [N_REQ-1:0]  slot_valid;
  logic [N_REQ-1:0]  slot_rw;
  logic [DATA_W-1:0] slot_data [N_REQ];
  logic [N_REQ-1:0]  drain;
  logic [NCH-1:0]    resp_ready;
  logic              id_ok;
  logic              accept;

  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_rw;
  logic [DATA_W-1:0] ch_data [NCH];

  assign resp_ready = {io_requestor_3_resp_ready, io_requestor_2_resp_ready,
                       io_requestor_1_resp_ready, io_requestor_0_resp_ready};
  assign drain      = slot_valid & resp_ready[N_REQ-1:0];

  // Out-of-range ids are never accepted, so they cannot touch mem.
  assign id_ok  = (int'(io_mem_req_bits_id) < N_REQ);
  assign io_mem_req_ready = id_ok &&
                            (!slot_valid[io_mem_req_bits_id] || drain[io_mem_req_bits_id]);
  assign accept = io_mem_req_valid && io_mem_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      slot_rw    <= '0;
      for (int k = 0; k < N_REQ; k++) slot_data[k] <= '0;
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      slot_valid <= slot_valid & ~drain;
      // A refill on the same edge as a drain overrides the clear above.
      if (accept) begin
        slot_valid[io_mem_req_bits_id] <= 1'b1;
        slot_rw[io_mem_req_bits_id]    <= io_mem_req_bits_rw;
        slot_data[io_mem_req_bits_id]  <= io_mem_req_bits_rw ? io_mem_req_bits_data
                                                              : mem[io_mem_req_bits_addr];
        if (io_mem_req_bits_rw) mem[io_mem_req_bits_addr] <= io_mem_req_bits_data;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    if (k < N_REQ) begin : g_used
      assign ch_valid[k] = slot_valid[k];
      assign ch_rw[k]    = slot_rw[k];
      assign ch_data[k]  = slot_data[k];
    end else begin : g_unused
      assign ch_valid[k] = 1'b0;
      assign ch_rw[k]    = 1'b0;
      assign ch_data[k]  = '0;
    end
  end

  assign io_requestor_0_resp_valid     = ch_valid[0];
  assign io_requestor_0_resp_bits_data = ch_data[0];
  assign io_requestor_0_resp_bits_rw   = ch_rw[0];
  assign io_requestor_1_resp_valid     = ch_valid[1];
  assign io_requestor_1_resp_bits_data = ch_data[1];
  assign io_requestor_1_resp_bits_rw   = ch_rw[1];
  assign io_requestor_2_resp_valid     = ch_valid[2];
  assign io_requestor_2_resp_bits_data = ch_data[2];
  assign io_requestor_2_resp_bits_rw   = ch_rw[2];
  assign io_requestor_3_resp_valid     = ch_valid[3];
  assign io_requestor_3_resp_bits_data = ch_data[3];
  assign io_requestor_3_resp_bits_rw   = ch_rw[3];

  assign io_busy = |slot_valid;
endmodule

// File: doc/vec_mem_responder.md
# vec_mem_responder

Memory-side responder for the vectored requestor interface. It accepts one request per cycle from the shared memory port, performs a read or write on a small internal register file, and returns the response to the originating requestor on that requestor's own response channel. Each requestor has a one-entry response holding slot, so a stalled requestor back-pressures only requests addressed to it.

## Interface

Parameters:
- N_REQ, 4, number of requestor response channels; ports are indexed k = 0..N_REQ-1
- ID_W, 2, requestor id width, log2(N_REQ)
- ADDR_W, 4, register-file address width; DEPTH = 2^ADDR_W words
- DATA_W, 8, data width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- io_mem_req_valid  in  1  request present
- io_mem_req_ready  out  1  request accepted this cycle when valid && ready
- io_mem_req_bits_id  in  ID_W  index of the requestor that receives the response
- io_mem_req_bits_rw  in  1  1 = write, 0 = read
- io_mem_req_bits_addr  in  ADDR_W  word address
- io_mem_req_bits_data  in  DATA_W  write data; ignored on reads
- io_requestor_k_resp_valid  out  1  response k pending
- io_requestor_k_resp_ready  in  1  requestor k consumes the response
- io_requestor_k_resp_bits_data  out  DATA_W  read data, or the written data for a write ack
- io_requestor_k_resp_bits_rw  out  1  echo of the request rw bit
- io_busy  out  1  OR of all resp_valid

## Operation

- State: DEPTH x DATA_W register file `mem`, plus per-slot regs `slot_valid[k]`, `slot_data[k]`, `slot_rw[k]`.
- Slot k drains when slot_valid[k] && io_requestor_k_resp_ready. A drained slot clears at the next edge unless it is refilled on the same edge.
- io_mem_req_ready = !slot_valid[id] || drain[id], where id = io_mem_req_bits_id. The path is combinational from io_mem_req_bits_id and io_requestor_id_resp_ready.
- Accept (valid && ready):
  - Write: mem[addr] <= data. Slot id loads data, rw = 1.
  - Read: slot id loads the current mem[addr] value (pre-edge), rw = 0.
  - slot_valid[id] <= 1.
- Simultaneous drain and refill of the same slot: the slot stays valid and holds the new response. No bubble occurs and no response is lost.
- Drains on other slots proceed independently in the same cycle.
- Requests not accepted have no side effect; mem is not written on a stalled write.
- An id ≥ N_REQ cannot occur with the defaults. For other parameter values it is don't-care, but it must not write mem.
- resp_bits_* hold stable while resp_valid is high and not drained.
- Reset (any cycle, including mid-traffic): all slot_valid <= 0, all slot_data and slot_rw <= 0, all mem words <= 0. Any pending response is discarded.

## Timing

- Reset values: all io_requestor_k_resp_valid = 0, all resp_bits_* = 0, io_busy = 0. io_mem_req_ready = 1 from the first cycle after reset.
- Latency: a request accepted on edge t presents resp_valid on its channel from edge t onward, i.e. visible in the cycle after acceptance. This is 1 cycle of latency.
- Throughput: 1 request/cycle sustained, provided either the target slot is empty or its requestor drains every cycle.
- Read-after-write: a write accepted at edge t is visible to a read accepted at edge t+1 or later.
- Back-pressure is per id. A full, undrained slot k blocks only requests with id = k.

## Test plan

- Reset, then write id=2 addr=5 data=0xA5 -> next cycle io_requestor_2_resp_valid = 1, bits_data = 0xA5, bits_rw = 1. The other channels stay 0 and io_busy = 1.
- After the write above, read id=0 addr=5 on the cycle following the drain -> io_requestor_0_resp_bits_data = 0xA5, rw = 0. A read of unwritten addr 3 returns 0x00.
- Hold io_requestor_1_resp_ready = 0 and issue two requests with id=1 -> the first is accepted and the second sees io_mem_req_ready = 0 until resp_ready is raised. Meanwhile a request with id=3 is accepted.
- Hold io_requestor_0_resp_ready = 1 and stream 8 reads with id=0 on consecutive cycles -> all accepted back-to-back (ready = 1 every cycle), and 8 responses appear in order with no bubble.
- Assert reset while slots 0 and 2 are valid -> next cycle all resp_valid = 0 and io_busy = 0. A read of the previously written address returns 0x00.
- Write a stalled request (id slot full, ready = 0) to addr 7 data 0x3C, then drop it -> a later read of addr 7 returns 0x00.
